// File: rtl/tas_tx.sv
// tas_tx: LSB-first serial packet transmitter (header + NUM_DATA bytes).
// Define TAS_TX_HDR_CHECK_EN to drop packets whose header is not A5/C3.
module tas_tx #(
  parameter int NUM_DATA   = 4,
  parameter int GAP_CYCLES = 4,
  parameter int BAUD_DIV   = 1
) (
  input  logic                  clk_50,
  input  logic                  reset,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  logic [7:0]            pkt_hdr,
  input  logic [8*NUM_DATA-1:0] pkt_data,
  output logic                  serial_data,
  output logic                  data_ena,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  pkt_err
);

  localparam int BW = (NUM_DATA + 1) * 8;
  localparam int CW = $clog2(NUM_DATA + 1);
  localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] BAUD_LAST = DW'(BAUD_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(NUM_DATA);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, TAIL} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic [DW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   byte_q, byte_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            ser_q, ser_d;
  logic            ena_q, ena_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            accept;
  logic            hdr_ok;

  assign accept = pkt_valid && ready_q && (state_q == IDLE);

`ifdef TAS_TX_HDR_CHECK_EN
  logic err_q;

  assign hdr_ok = (pkt_hdr == 8'hA5) || (pkt_hdr == 8'hC3);

  always_ff @(posedge clk_50) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= accept && !hdr_ok;
  end

  assign pkt_err = err_q;
`else
  assign hdr_ok  = 1'b1;
  assign pkt_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    ser_d   = 1'b0;
    ena_d   = 1'b0;
    ready_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept && hdr_ok) begin
          state_d = SHIFT;
          buf_d   = {pkt_data, pkt_hdr};
          ser_d   = pkt_hdr[0];
          ena_d   = 1'b1;
          ready_d = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      SHIFT: begin
        ena_d = 1'b1;
        ser_d = ser_q;
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          // buf_q[0] always holds the bit on the wire
          buf_d  = buf_q >> 1;
          if (bit_q == 3'd7) begin
            ena_d = 1'b0;
            ser_d = 1'b0;
            bit_d = '0;
            gap_d = '0;
            if (byte_q == BYTE_LAST) begin
              state_d = TAIL;
            end else begin
              state_d = GAP;
              byte_d  = byte_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            ser_d = buf_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = SHIFT;
          ena_d   = 1'b1;
          ser_d   = buf_q[0];
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      TAIL: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      ser_q   <= 1'b0;
      ena_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      ser_q   <= ser_d;
      ena_q   <= ena_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign serial_data = ser_q;
  assign data_ena    = ena_q;
  assign pkt_ready   = ready_q;
  assign pkt_done    = done_q;
  assign busy        = (state_q != IDLE);

endmodule
